// File: rtl/gen_scheduler_if.sv
// Mode/grid handshake bundle between the scheduler and its mode FSM and cell grid.
// master = scheduler side (issues clear/seed/update), slave = mode FSM + grid side.
interface gen_scheduler_if #(
    parameter int GEN_W = 16
);
    logic             rst_mode;
    logic             run_mode;
    logic             rnd_mode;
    logic             step;
    logic [1:0]       speed;
    logic             grid_done;
    logic             grid_clear;
    logic             lfsr_en;
    logic             seed_load;
    logic             grid_upd;
    logic             running;
    logic [GEN_W-1:0] gen_count;

    modport master (
        input  rst_mode, run_mode, rnd_mode, step, speed, grid_done,
        output grid_clear, lfsr_en, seed_load, grid_upd, running, gen_count
    );

    modport slave (
        output rst_mode, run_mode, rnd_mode, step, speed, grid_done,
        input  grid_clear, lfsr_en, seed_load, grid_upd, running, gen_count
    );
endinterface

// File: rtl/gen_scheduler.sv
// Game-of-Life generation scheduler: grid clear, LFSR seed window, rate-timed update requests.
// Outputs decode registered state one cycle after the deciding edge; an update waits indefinitely for grid_done.
module gen_scheduler #(
    parameter int BASE_PERIOD = 12500000,
    parameter int DIV_W       = 24,
    parameter int SEED_CYCLES = 64,
    parameter int GEN_W       = 16
) (
    input  logic            clk,
    input  logic            reset,
    gen_scheduler_if.master sched
);
    typedef enum logic [2:0] {
        S_CLEAR     = 3'd0,
        S_IDLE      = 3'd1,
        S_SEED      = 3'd2,
        S_SEED_HOLD = 3'd3,
        S_WAIT      = 3'd4,
        S_UPDATE    = 3'd5
    } state_t;

    localparam int SEED_W = (SEED_CYCLES > 1) ? $clog2(SEED_CYCLES) : 1;
    localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(SEED_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic              step_q;
    logic              upd_first;
    logic [SEED_W-1:0] seed_cnt;
    logic [DIV_W-1:0]  presc;
    logic [GEN_W-1:0]  gen_count;
    logic [DIV_W:0]    period_sel;
    logic [DIV_W-1:0]  presc_load;
    logic              step_rise;
    logic              seed_last;
    logic              done_ok;

    assign step_rise  = sched.step & ~step_q;
    assign seed_last  = (seed_cnt == SEED_LAST);
    // The grid cannot answer in the same cycle it is asked.
    assign done_ok    = sched.grid_done & ~upd_first;
    assign period_sel = (DIV_W+1)'(BASE_PERIOD >> sched.speed);
    assign presc_load = (period_sel == '0) ? '0 : DIV_W'(period_sel - 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        sched.grid_clear = 1'b0;
        sched.lfsr_en    = 1'b0;
        sched.seed_load  = 1'b0;
        sched.grid_upd   = 1'b0;
        sched.running    = 1'b0;
        case (state)
            S_CLEAR: begin
                sched.grid_clear = 1'b1;
                if (!sched.rst_mode) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (sched.rnd_mode)      state_nxt = S_SEED;
                else if (sched.run_mode) state_nxt = S_WAIT;
                else if (step_rise)      state_nxt = S_UPDATE;
            end
            S_SEED: begin
                sched.lfsr_en   = 1'b1;
                sched.seed_load = 1'b1;
                if (seed_last) begin
                    if (sched.rnd_mode) state_nxt = S_SEED_HOLD;
                    else                state_nxt = S_IDLE;
                end
            end
            S_SEED_HOLD: begin
                sched.lfsr_en = 1'b1;
                if (!sched.rnd_mode) state_nxt = S_IDLE;
            end
            S_WAIT: begin
                sched.running = sched.run_mode;
                if (!sched.run_mode)  state_nxt = S_IDLE;
                else if (presc == '0) state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                sched.running  = sched.run_mode;
                sched.grid_upd = upd_first;
                if (done_ok) begin
                    if (sched.run_mode) state_nxt = S_WAIT;
                    else                state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_CLEAR;
        endcase
        if (sched.rst_mode) state_nxt = S_CLEAR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q    <= 1'b0;
            upd_first <= 1'b0;
            seed_cnt  <= '0;
            presc     <= '0;
            gen_count <= '0;
        end else begin
            step_q    <= sched.step;
            upd_first <= (state_nxt == S_UPDATE) && (state != S_UPDATE);
            seed_cnt  <= (state == S_SEED && !seed_last) ? seed_cnt + 1'b1 : '0;

            // Speed is sampled only here, so a change applies from the next generation.
            if (state_nxt == S_WAIT && state != S_WAIT) presc <= presc_load;
            else if (state == S_WAIT && presc != '0)    presc <= presc - 1'b1;

            if (sched.rst_mode || state == S_CLEAR)  gen_count <= '0;
            else if (state == S_SEED && seed_last)   gen_count <= '0;
            else if (state == S_UPDATE && done_ok)   gen_count <= gen_count + 1'b1;
        end
    end

    assign sched.gen_count = gen_count;
endmodule
